mac_tx_buffer: RTL and testbench
================================

Name: mac_tx_buffer

Overview:
- Frame-level staging buffer directly upstream of the MAC transmit encoder.
- Accepts payload bytes from a producer (ARP/IP/UDP builders) as a valid/ready byte stream with a last flag.
- Stores each whole frame in one of two banks (ping-pong) and replays it to the encoder's en/mac_payload/send_next interface.
- Enforces the minimum inter-frame gap so en never re-rises while the encoder is still padding, sending FCS or in IPG.

Parameters:
- BANK_DEPTH, 2048: bytes per bank; power of two, at least MAX_PAYLOAD.
- MAX_PAYLOAD, 1500: largest accepted payload in bytes; longer frames are dropped.
- GAP_CYCLES, 160: cycles en is held low after a frame. Covers worst-case pad (46) + FCS (4) + IPG (96) + margin at 1 byte/clk.

Ports:
- clk  in  1  system clock (125 MHz, 1000M build).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer byte valid.
- in_data  in  8  producer payload byte.
- in_last  in  1  marks final byte of the frame.
- in_dest  in  48  destination MAC; sampled on the in_last beat.
- in_ethertype  in  16  ethertype; sampled on the in_last beat.
- in_ready  out  1  buffer can accept a byte this cycle.
- en  out  1  to encoder: frame request / payload valid.
- mac_payload  out  8  to encoder: current payload byte.
- mac_dest  out  48  to encoder: held constant for the whole frame.
- ethertype  out  16  to encoder: held constant for the whole frame.
- send_next  in  1  from encoder: current mac_payload byte consumed this cycle.
- drop_pulse  out  1  one-cycle pulse when an oversize frame is discarded.

Behaviour:
- Reset values: en=0, mac_payload=0, mac_dest=0, ethertype=0, in_ready=0 for the reset cycle and then 1, drop_pulse=0. Both banks empty, write bank=0, read bank=0. Reset mid-frame abandons all frames with no partial output; en is low the cycle after rst.
- Each bank holds length[10:0], dest, ethertype and a full flag.

Write FSM (W_FILL, W_DROP):
- in_ready = (write bank not full) and not in reset.
- W_FILL: on each in_valid&&in_ready, write the byte at wr_ptr and increment wr_ptr.
- On the in_last beat with total length <= MAX_PAYLOAD: latch length, dest and ethertype, set bank full, toggle write bank, clear wr_ptr.
- On a beat that would make length MAX_PAYLOAD+1: go to W_DROP and pulse drop_pulse.
- W_DROP: in_ready=1; consume bytes until in_last, then clear wr_ptr and return to W_FILL. The bank is not marked full.
- in_last on the first byte is a valid 1-byte frame. Zero-length frames cannot be expressed.

Read FSM (R_IDLE, R_PREFETCH, R_SEND, R_GAP):
- R_IDLE: if the read bank is full, issue RAM read of addr 0 and go to R_PREFETCH.
- R_PREFETCH (1 cycle, RAM latency 1): load byte0 into mac_payload, drive mac_dest/ethertype from bank metadata, assert en, issue read of addr 1, go to R_SEND.
- R_SEND:
  - Every cycle send_next=1, mac_payload must advance to the next byte on the following cycle. The encoder consumes on consecutive cycles, so a read is kept one ahead.
  - On the send_next cycle that consumes byte length-1, en<=0 (en is low the next cycle).
  - Clear the bank full flag, toggle the read bank, load the gap counter, go to R_GAP.
- R_GAP: en=0, count GAP_CYCLES cycles, then go to R_IDLE.
- en never rises in the same cycle as leaving R_GAP; the earliest rise is 2 cycles later (through R_PREFETCH).
- send_next while not in R_SEND is ignored.
- Simultaneous events: the write side may fill the other bank while the read side sends. The write side filling the bank being freed in the same cycle the read side clears it is allowed; the clear takes effect first.
- Short frames (<46 bytes): no padding here; the encoder pads.
- Width rules: length and pointers are clog2(BANK_DEPTH) bits; the gap counter is 8 bits. No wrap within a frame because length <= MAX_PAYLOAD < BANK_DEPTH.

Decomposition:
- Package mac_pkg: MAX_PAYLOAD, MIN_PAYLOAD (46), FCS_BYTES (4), IPG_BYTES (96), derived GAP_CYCLES default, and read/write state enums.
- Sub-module bram_sdp: simple dual-port RAM, 1 write port, 1 read port, registered read, depth 2*BANK_DEPTH. Address = {bank, ptr}.

Test Plan:
- 60-byte frame 0x00..0x3B, dest 48'hffffffffffff, ethertype 16'h0806 → en rises 2 cycles after in_last. mac_payload = 0x00,0x01,… on consecutive send_next cycles. en falls the cycle after 0x3B is consumed. mac_dest/ethertype are stable throughout.
- Two 10-byte frames back-to-back → second frame's en rises exactly GAP_CYCLES+2 cycles after the first's en fall. Second frame's bytes are correct (ping-pong).
- 1501-byte frame, then a 1-byte frame 0xA5 → drop_pulse once, oversize frame never transmitted. Then en asserts with mac_payload=0xA5, and en falls after one send_next.
- Producer sends 3 frames while the encoder is stalled (send_next low) → in_ready=0 after 2 frames. It reasserts the cycle the first frame completes, and frame order is preserved.
- rst asserted mid-R_SEND at byte 20 of 100 → en=0 the next cycle, all outputs at reset values, and the next frame starts from byte 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, FSM encodings and frame metadata for the MAC transmit staging buffer.
package mac_pkg;

  localparam int unsigned MAX_PAYLOAD = 1500;
  localparam int unsigned MIN_PAYLOAD = 46;
  localparam int unsigned FCS_BYTES   = 4;
  localparam int unsigned IPG_BYTES   = 96;
  localparam int unsigned GAP_MARGIN  = 14;
  // Worst-case encoder tail at 1 byte/clk: pad + FCS + IPG, plus slack.
  localparam int unsigned GAP_CYCLES  = MIN_PAYLOAD + FCS_BYTES + IPG_BYTES + GAP_MARGIN;

  typedef enum logic {
    W_FILL,
    W_DROP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PREFETCH,
    R_SEND,
    R_GAP
  } rd_state_t;

  typedef struct packed {
    logic [47:0] dest;
    logic [15:0] ethertype;
  } frame_meta_t;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM with registered read; a same-address write is forwarded to the read port.
module bram_sdp #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Forwarding lets a 1-byte frame be read back in the cycle it is committed.
  always_ff @(posedge clk) begin
    if (re) rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/mac_tx_buffer.sv
// Ping-pong frame staging buffer feeding the MAC transmit encoder, with oversize drop
// and an enforced inter-frame gap on en.
module mac_tx_buffer
  import mac_pkg::*;
#(
  parameter int unsigned BANK_DEPTH  = 2048,
  parameter int unsigned MAX_PAYLOAD = mac_pkg::MAX_PAYLOAD,
  parameter int unsigned GAP_CYCLES  = mac_pkg::GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic [47:0] in_dest,
  input  logic [15:0] in_ethertype,
  output logic        in_ready,
  output logic        en,
  output logic [7:0]  mac_payload,
  output logic [47:0] mac_dest,
  output logic [15:0] ethertype,
  input  logic        send_next,
  output logic        drop_pulse
);

  localparam int unsigned PW = $clog2(BANK_DEPTH);

  wr_state_t      wr_state;
  logic           wr_bank;
  logic [PW-1:0]  wr_ptr;

  rd_state_t      rd_state;
  logic           rd_bank;
  logic [PW-1:0]  rd_ptr;
  logic [7:0]     gap_cnt;

  logic [1:0]     full;
  logic [PW-1:0]  len  [2];
  frame_meta_t    meta [2];

  logic           fill_beat;
  logic           oversize;
  logic           commit;
  logic           rd_start;
  logic           rd_last;
  logic           rd_en;
  logic [7:0]     rd_data;

  assign in_ready  = !rst && ((wr_state == W_DROP) || !full[wr_bank]);
  assign fill_beat = in_valid && in_ready && (wr_state == W_FILL);
  assign oversize  = fill_beat && (wr_ptr == PW'(MAX_PAYLOAD));
  assign commit    = fill_beat && in_last && !oversize;

  // A frame committing into the idle read bank starts the read without waiting for full.
  assign rd_start = (rd_state == R_IDLE) &&
                    (full[rd_bank] || (commit && (wr_bank == rd_bank)));
  assign rd_last  = (rd_state == R_SEND) && send_next && (rd_ptr == len[rd_bank] + PW'(1));
  assign rd_en    = rd_start || (rd_state == R_PREFETCH) || ((rd_state == R_SEND) && send_next);

  bram_sdp #(
    .ADDR_W (PW + 1),
    .WIDTH  (8)
  ) u_ram (
    .clk     (clk),
    .we      (fill_beat),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (in_data),
    .re      (rd_en),
    .rd_addr ({rd_bank, rd_ptr}),
    .rd_data (rd_data)
  );

  // Write FSM: fill the write bank, or discard the rest of an oversize frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= W_FILL;
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (wr_state)
        W_FILL: begin
          if (fill_beat) begin
            if (oversize) begin
              drop_pulse <= 1'b1;
              wr_ptr     <= '0;
              if (!in_last) wr_state <= W_DROP;
            end else if (in_last) begin
              wr_bank <= ~wr_bank;
              wr_ptr  <= '0;
            end else begin
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
        end
        W_DROP: begin
          if (in_valid && in_last) wr_state <= W_FILL;
        end
        default: wr_state <= W_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      len[wr_bank]  <= wr_ptr + PW'(1);
      meta[wr_bank] <= '{dest: in_dest, ethertype: in_ethertype};
    end
  end

  // The read-side clear is applied before the write-side set.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (rd_last) full[rd_bank] <= 1'b0;
      if (commit)  full[wr_bank] <= 1'b1;
    end
  end

  // Read FSM: prefetch byte 0, stream one byte ahead of the encoder, then hold off for the gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= R_IDLE;
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      gap_cnt     <= '0;
      en          <= 1'b0;
      mac_payload <= '0;
      mac_dest    <= '0;
      ethertype   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (rd_start) begin
            rd_ptr   <= PW'(1);
            rd_state <= R_PREFETCH;
          end
        end
        R_PREFETCH: begin
          mac_payload <= rd_data;
          mac_dest    <= meta[rd_bank].dest;
          ethertype   <= meta[rd_bank].ethertype;
          en          <= 1'b1;
          rd_ptr      <= rd_ptr + PW'(1);
          rd_state    <= R_SEND;
        end
        R_SEND: begin
          if (rd_last) begin
            en       <= 1'b0;
            rd_bank  <= ~rd_bank;
            rd_ptr   <= '0;
            gap_cnt  <= 8'(GAP_CYCLES - 1);
            rd_state <= R_GAP;
          end else if (send_next) begin
            mac_payload <= rd_data;
            rd_ptr      <= rd_ptr + PW'(1);
          end
        end
        R_GAP: begin
          if (gap_cnt == 8'd0) rd_state <= R_IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_buffer.sv
// Directed bench for mac_tx_buffer: framing, ping-pong, gap timing, oversize drop, backpressure, reset.
module tb_mac_tx_buffer;

  localparam int unsigned GAP = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic [47:0] in_dest;
  logic [15:0] in_ethertype;
  logic        in_ready;
  logic        en;
  logic [7:0]  mac_payload;
  logic [47:0] mac_dest;
  logic [15:0] ethertype;
  logic        send_next;
  logic        drop_pulse;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int drop_cnt = 0;
  int drop_cyc = 0;
  int en_cnt   = 0;

  mac_tx_buffer #(
    .BANK_DEPTH  (2048),
    .MAX_PAYLOAD (1500),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_dest      (in_dest),
    .in_ethertype (in_ethertype),
    .in_ready     (in_ready),
    .en           (en),
    .mac_payload  (mac_payload),
    .mac_dest     (mac_dest),
    .ethertype    (ethertype),
    .send_next    (send_next),
    .drop_pulse   (drop_pulse)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (drop_pulse) begin
      drop_cnt = drop_cnt + 1;
      drop_cyc = cyc;
    end
    if (en) en_cnt = en_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one frame of bytes base, base+1, ...; reports first-accept and in_last cycles.
  task automatic tx_frame(input string name, input int n, input logic [7:0] base,
                          input logic [47:0] dest, input logic [15:0] et,
                          output int first_cyc, output int last_cyc);
    int guard;
    first_cyc = -1;
    last_cyc  = -1;
    in_dest      = dest;
    in_ethertype = et;
    in_valid     = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = 8'(int'(base) + i);
      in_last = (i == n - 1);
      guard = 0;
      while (!in_ready && guard < 5000) begin
        tick();
        guard++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL %s tx_ready_timeout: byte %0d in_ready=%0b required 1", name, i, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      if (i == 0) first_cyc = cyc;
      if (i == n - 1) last_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume one frame as an always-ready encoder and check bytes and metadata.
  task automatic rx_frame(input string name, input int n, input logic [7:0] base,
                          input logic [47:0] dest, input logic [15:0] et,
                          output int rise_cyc, output int fall_cyc);
    int guard;
    logic [7:0] exp_b;
    rise_cyc  = -1;
    fall_cyc  = -1;
    send_next = 1'b0;
    guard = 0;
    while (en !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    checks++;
    if (en !== 1'b1) begin
      failures++;
      $display("FAIL %s en_rise_timeout: en=%0b required 1", name, en);
      return;
    end
    rise_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      exp_b = 8'(int'(base) + i);
      checks++;
      if (en !== 1'b1 || mac_payload !== exp_b || mac_dest !== dest || ethertype !== et) begin
        failures++;
        $display("FAIL %s byte%0d: en=%0b payload=%02h dest=%012h et=%04h required en=1 payload=%02h dest=%012h et=%04h",
                 name, i, en, mac_payload, mac_dest, ethertype, exp_b, dest, et);
      end
      send_next = 1'b1;
      tick();
    end
    send_next = 1'b0;
    fall_cyc = cyc;
    checks++;
    if (en !== 1'b0) begin
      failures++;
      $display("FAIL %s en_fall: en=%0b required 0", name, en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_dest = '0; in_ethertype = '0; send_next = 1'b0;
    tick();
    tick();
    checks++;
    if (en !== 1'b0 || mac_payload !== 8'h00 || mac_dest !== 48'h0 || ethertype !== 16'h0 ||
        drop_pulse !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: en=%0b payload=%02h dest=%012h et=%04h drop=%0b ready=%0b required all 0",
               en, mac_payload, mac_dest, ethertype, drop_pulse, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_release: in_ready=%0b required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_single_frame();
    int f, l, r, fl;
    tx_frame("t60", 60, 8'h00, 48'hffffffffffff, 16'h0806, f, l);
    rx_frame("t60", 60, 8'h00, 48'hffffffffffff, 16'h0806, r, fl);
    checks++;
    if (r !== l + 2) begin
      failures++;
      $display("FAIL t60_en_rise: rise_cyc=%0d required %0d", r, l + 2);
    end
    checks++;
    if (fl !== r + 60) begin
      failures++;
      $display("FAIL t60_en_fall: fall_cyc=%0d required %0d", fl, r + 60);
    end
  endtask

  task automatic test_back_to_back();
    int f, l, ra, fa, rb, fb;
    tx_frame("b2b_a", 10, 8'h10, 48'h001122334455, 16'h0800, f, l);
    tx_frame("b2b_b", 10, 8'h80, 48'h66778899aabb, 16'h86dd, f, l);
    rx_frame("b2b_a", 10, 8'h10, 48'h001122334455, 16'h0800, ra, fa);
    rx_frame("b2b_b", 10, 8'h80, 48'h66778899aabb, 16'h86dd, rb, fb);
    checks++;
    if (rb - fa !== GAP + 2) begin
      failures++;
      $display("FAIL b2b_gap: rise_b-fall_a=%0d required %0d", rb - fa, GAP + 2);
    end
  endtask

  task automatic test_oversize();
    int f, l, r, fl, d0, e0;
    d0 = drop_cnt;
    e0 = en_cnt;
    // Overflow beat is itself in_last.
    tx_frame("ovr1501", 1501, 8'h00, 48'h0a0b0c0d0e0f, 16'h0800, f, l);
    tick();
    checks++;
    if (drop_cnt !== d0 + 1 || drop_cyc !== l + 1) begin
      failures++;
      $display("FAIL ovr1501_drop: drops=%0d at cyc %0d required %0d at cyc %0d",
               drop_cnt - d0, drop_cyc, 1, l + 1);
    end
    // Overflow beat is mid-frame, so the tail goes through the drop state.
    tx_frame("ovr1503", 1503, 8'h00, 48'h0a0b0c0d0e0f, 16'h0800, f, l);
    tick();
    checks++;
    if (drop_cnt !== d0 + 2 || drop_cyc !== f + 1501) begin
      failures++;
      $display("FAIL ovr1503_drop: drops=%0d at cyc %0d required %0d at cyc %0d",
               drop_cnt - d0, drop_cyc, 2, f + 1501);
    end
    checks++;
    if (en_cnt !== e0) begin
      failures++;
      $display("FAIL ovr_no_tx: en_cycles=%0d required 0", en_cnt - e0);
    end
    tx_frame("one", 1, 8'ha5, 48'h112233445566, 16'h0806, f, l);
    rx_frame("one", 1, 8'ha5, 48'h112233445566, 16'h0806, r, fl);
    checks++;
    if (r !== l + 2 || fl !== r + 1) begin
      failures++;
      $display("FAIL one_timing: rise=%0d fall=%0d required rise=%0d fall=%0d", r, fl, l + 2, l + 3);
    end
    tx_frame("max1500", 1500, 8'h00, 48'hdeadbeef0001, 16'h0800, f, l);
    rx_frame("max1500", 1500, 8'h00, 48'hdeadbeef0001, 16'h0800, r, fl);
    checks++;
    if (drop_cnt !== d0 + 2) begin
      failures++;
      $display("FAIL max1500_no_drop: drops=%0d required 2", drop_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    int f1, l1, f2, l2, f3, l3, r1, fl1, r2, fl2, r3, fl3;
    tx_frame("bp1", 5, 8'h20, 48'h000000000001, 16'h0001, f1, l1);
    tx_frame("bp2", 5, 8'h30, 48'h000000000002, 16'h0002, f2, l2);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_low: in_ready=%0b required 0", in_ready);
    end
    fork
      tx_frame("bp3", 5, 8'h50, 48'h000000000003, 16'h0003, f3, l3);
      rx_frame("bp1", 5, 8'h20, 48'h000000000001, 16'h0001, r1, fl1);
    join
    checks++;
    if (f3 !== fl1) begin
      failures++;
      $display("FAIL bp_ready_reassert: first_accept=%0d required %0d", f3, fl1);
    end
    rx_frame("bp2", 5, 8'h30, 48'h000000000002, 16'h0002, r2, fl2);
    checks++;
    if (r2 - fl1 !== GAP + 2) begin
      failures++;
      $display("FAIL bp_gap: rise2-fall1=%0d required %0d", r2 - fl1, GAP + 2);
    end
    rx_frame("bp3", 5, 8'h50, 48'h000000000003, 16'h0003, r3, fl3);
  endtask

  task automatic test_reset_mid_frame();
    int f, l, r, fl, guard, e0;
    tx_frame("rst100", 100, 8'h00, 48'hcafef00d0001, 16'h0800, f, l);
    guard = 0;
    while (en !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      send_next = 1'b1;
      tick();
    end
    send_next = 1'b0;
    checks++;
    if (en !== 1'b1 || mac_payload !== 8'd20) begin
      failures++;
      $display("FAIL rst_pre_byte20: en=%0b payload=%02h required en=1 payload=14", en, mac_payload);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (en !== 1'b0 || mac_payload !== 8'h00 || mac_dest !== 48'h0 || ethertype !== 16'h0 ||
        drop_pulse !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs: en=%0b payload=%02h dest=%012h et=%04h drop=%0b ready=%0b required all 0",
               en, mac_payload, mac_dest, ethertype, drop_pulse, in_ready);
    end
    rst = 1'b0;
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (en_cnt !== e0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_no_partial: en_cycles=%0d ready=%0b required 0 and 1", en_cnt - e0, in_ready);
    end
    tx_frame("rst_next", 8, 8'h00, 48'h0000beef0002, 16'h0806, f, l);
    rx_frame("rst_next", 8, 8'h00, 48'h0000beef0002, 16'h0806, r, fl);
    checks++;
    if (r !== l + 2) begin
      failures++;
      $display("FAIL rst_next_rise: rise_cyc=%0d required %0d", r, l + 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_oversize();
    test_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
